frame_draw_scheduler: RTL and testbench
=======================================

Name: frame_draw_scheduler

Overview:
- Per-frame sequencer that shares the single pixel-plotter datapath among NUM_CLIENTS sprite controllers (player ship, enemies, projectiles).
- On each frame tick it runs an ERASE pass over every client drawn last frame, then a DRAW pass over every client active this frame.
- It grants the plotter to one client at a time and tells that client which op to perform.
- Sits between the frame-rate tick generator and the per-object control blocks; it replaces each client's private state input.

Parameters:
NUM_CLIENTS, 4, number of sprite clients (index 0 = highest priority, served first)
TIMEOUT, 4095, max cycles to wait for plot_done before abandoning a job
CNT_W, 8, width of overrun counter

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle pulse, start of frame
active  in  NUM_CLIENTS  client i visible this frame
plot_done  in  1  one-cycle pulse from plotter, current job finished
grant  out  NUM_CLIENTS  one-hot, client owning the plotter; all-zero when none
sched_op  out  2  2'b01 erase, 2'b00 draw; valid while grant nonzero
plot_start  out  1  one-cycle pulse, plotter begins job for granted client
busy  out  1  high whenever state != IDLE
overrun  out  1  one-cycle pulse, frame_tick arrived while busy
overrun_cnt  out  CNT_W  saturating count of overruns
timeout_err  out  1  sticky, set when any job hits TIMEOUT

Behaviour:
- Reset: all outputs 0, state IDLE, idx 0, drawn_mask 0, draw_snap 0, wait counter 0. Reset mid-job abandons the job; the plotter must be reset by the same reset_n.
- States: IDLE, SCAN, ISSUE, WAIT. Phase register: ERASE or DRAW.
- IDLE: on frame_tick: draw_snap <= active; erase_snap <= drawn_mask; phase <= ERASE; idx <= 0; go to SCAN.
- SCAN: examines one index per cycle. Eligible means erase_snap[idx] in ERASE, draw_snap[idx] in DRAW.
  - Eligible -> ISSUE.
  - Not eligible -> ADVANCE.
- ISSUE: grant[idx]=1, sched_op per phase, plot_start=1 for exactly this cycle; clear wait counter; go to WAIT.
- WAIT: grant and sched_op held stable.
  - plot_done=1 -> ADVANCE. In the DRAW phase also set drawn_mask[idx]; in the ERASE phase clear drawn_mask[idx].
  - Wait counter == TIMEOUT -> timeout_err <= 1 and ADVANCE. drawn_mask[idx] is left unchanged on timeout.
  - plot_done is sampled only in WAIT; a pulse in any other state is ignored.
- ADVANCE (transition action, not a state):
  - idx < NUM_CLIENTS-1 -> idx+1, go to SCAN.
  - idx == NUM_CLIENTS-1 in ERASE -> phase DRAW, idx 0, go to SCAN.
  - idx == NUM_CLIENTS-1 in DRAW -> go to IDLE.
- Latency: frame_tick at cycle t with client 0 eligible gives SCAN at t+1 and plot_start/grant[0] at t+2.
  - Empty frame (no erase/draw bits) returns to IDLE after exactly 2*NUM_CLIENTS SCAN cycles.
- grant is deasserted in the cycle after plot_done; it is never nonzero in SCAN or IDLE.
- Inactive client disappears: it is erased in the next frame (present in drawn_mask), not drawn, and its drawn_mask bit is cleared.
- active changes mid-frame: ignored until the next accepted tick, because draw_snap is latched.
- frame_tick while busy: the tick is dropped, overrun pulses one cycle, and overrun_cnt increments, saturating at all-ones.
- frame_tick in the same cycle the FSM enters IDLE: the tick is treated as busy (dropped) and counts as an overrun.
- Wait counter width is clog2(TIMEOUT+1); it does not wrap.

Decomposition:
- Shared package (game_pkg): sched_op encodings OP_DRAW=2'b00, OP_ERASE=2'b01, OP_FIRE=2'b10 (reserved for clients); state enum; phase enum.
- One natural sub-module: sched_timeout_counter (clear/enable/expired) for the WAIT watchdog.
- Everything else stays in the top level.

Test Plan:
- Reset, then frame_tick with active=4'b0101 and plot_done 3 cycles after each plot_start:
  - ERASE pass issues nothing.
  - DRAW grants client 0 then client 2, sched_op=00, two plot_start pulses; drawn_mask=0101.
- Second tick with active=4'b0011:
  - ERASE grants 0 then 2 (op 01).
  - DRAW grants 0 then 1; final drawn_mask=0011.
- active=0 and drawn_mask=0, tick at t: busy high t+1..t+8, IDLE at t+9, no grant or plot_start.
- Tick while WAIT for client 1: overrun pulses once, overrun_cnt=1, current job completes, no restart.
- plot_done never returns: after TIMEOUT+1 WAIT cycles timeout_err=1, the scheduler advances to the next client, and the drawn bit is unchanged.
- Assert reset_n low during WAIT: next cycle grant=0, busy=0, drawn_mask=0, overrun_cnt=0, timeout_err=0.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared plotter op encodings and frame scheduler state types
package game_pkg;
  localparam logic [1:0] OP_DRAW  = 2'b00;
  localparam logic [1:0] OP_ERASE = 2'b01;
  localparam logic [1:0] OP_FIRE  = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_ISSUE, ST_WAIT} sched_state_t;
  typedef enum logic {PH_ERASE, PH_DRAW} sched_phase_t;
endpackage

// File: rtl/sched_timeout_counter.sv
// sched_timeout_counter: WAIT watchdog, counts enabled cycles and holds at TIMEOUT
module sched_timeout_counter #(
  parameter int TIMEOUT = 4095
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] r_cnt;
  assign o_expired = r_cnt == W'(TIMEOUT);
  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) r_cnt <= '0;
    else if (i_enable && !o_expired) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler: per-frame erase-then-draw sequencer sharing one pixel plotter
module frame_draw_scheduler
  import game_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int TIMEOUT     = 4095,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_tick,
  input  logic [NUM_CLIENTS-1:0] active,
  input  logic                   plot_done,
  output logic [NUM_CLIENTS-1:0] grant,
  output logic [1:0]             sched_op,
  output logic                   plot_start,
  output logic                   busy,
  output logic                   overrun,
  output logic [CNT_W-1:0]       overrun_cnt,
  output logic                   timeout_err
);
  localparam int IW = NUM_CLIENTS > 1 ? $clog2(NUM_CLIENTS) : 1;
  sched_state_t r_state, w_state_nxt;
  sched_phase_t r_phase;
  logic [IW-1:0] r_idx;
  logic [NUM_CLIENTS-1:0] r_draw_snap, r_erase_snap, r_drawn_mask;
  logic r_overrun, r_timeout_err;
  logic [CNT_W-1:0] r_overrun_cnt;
  logic w_elig, w_last, w_owns, w_adv, w_accept, w_expired;
  assign w_elig   = r_phase == PH_ERASE ? r_erase_snap[r_idx] : r_draw_snap[r_idx];
  assign w_last   = r_idx == IW'(NUM_CLIENTS - 1);
  assign w_owns   = r_state == ST_ISSUE || r_state == ST_WAIT;
  assign w_accept = r_state == ST_IDLE && frame_tick;
  // plot_done wins over a simultaneous expiry; both leave the client
  assign w_adv    = (r_state == ST_SCAN && !w_elig) ||
                    (r_state == ST_WAIT && (plot_done || w_expired));
  assign grant       = w_owns ? NUM_CLIENTS'(1) << r_idx : '0;
  assign sched_op    = w_owns && r_phase == PH_ERASE ? OP_ERASE : OP_DRAW;
  assign plot_start  = r_state == ST_ISSUE;
  assign busy        = r_state != ST_IDLE;
  assign overrun     = r_overrun;
  assign overrun_cnt = r_overrun_cnt;
  assign timeout_err = r_timeout_err;
  sched_timeout_counter #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (r_state == ST_ISSUE),
    .i_enable  (r_state == ST_WAIT),
    .o_expired (w_expired)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = ST_SCAN;
    else if (w_adv) w_state_nxt = w_last && r_phase == PH_DRAW ? ST_IDLE : ST_SCAN;
    else if (r_state == ST_SCAN) w_state_nxt = ST_ISSUE;
    else if (r_state == ST_ISSUE) w_state_nxt = ST_WAIT;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_phase       <= PH_ERASE;
      r_idx         <= '0;
      r_draw_snap   <= '0;
      r_erase_snap  <= '0;
      r_drawn_mask  <= '0;
      r_overrun     <= 1'b0;
      r_overrun_cnt <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_draw_snap  <= active;
        r_erase_snap <= r_drawn_mask;
        r_phase      <= PH_ERASE;
        r_idx        <= '0;
      end else if (w_adv) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) r_phase <= PH_DRAW;
      end
      if (r_state == ST_WAIT && plot_done) r_drawn_mask[r_idx] <= r_phase == PH_DRAW;
      if (r_state == ST_WAIT && !plot_done && w_expired) r_timeout_err <= 1'b1;
      r_overrun <= frame_tick && busy;
      if (frame_tick && busy && r_overrun_cnt != '1) r_overrun_cnt <= r_overrun_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb_frame_draw_scheduler: table-driven frames with a grant/op scoreboard plus corner sequences
module tb_frame_draw_scheduler;
  import game_pkg::*;
  localparam int N = 4, TO = 4095, CW = 8;
  logic clk = 0, reset_n = 0, frame_tick = 0, plot_done = 0;
  logic [N-1:0] active = '0;
  logic [N-1:0] grant;
  logic [1:0] sched_op;
  logic plot_start, busy, overrun, timeout_err;
  logic [CW-1:0] overrun_cnt;
  int total = 0, bad = 0;
  typedef struct { logic [N-1:0] g; logic [1:0] op; } exp_t;
  typedef struct { logic [N-1:0] act; logic [N-1:0] mask; int starts; } vec_t;
  exp_t sb[$];
  vec_t v[5];
  logic [N-1:0] model_mask = '0;

  frame_draw_scheduler #(.NUM_CLIENTS(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .active(active),
    .plot_done(plot_done), .grant(grant), .sched_op(sched_op), .plot_start(plot_start),
    .busy(busy), .overrun(overrun), .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_frame(input logic [N-1:0] act);
    for (int i = 0; i < N; i++) if (model_mask[i]) sb.push_back('{g: N'(1) << i, op: OP_ERASE});
    for (int i = 0; i < N; i++) if (act[i]) sb.push_back('{g: N'(1) << i, op: OP_DRAW});
    model_mask = act;
  endtask

  task automatic run_frame(input logic [N-1:0] act, input int dly, output int starts);
    int k;
    exp_t e;
    starts = 0;
    k = 0;
    active = act;
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    for (int c = 0; c < 2000 && busy; c++) begin
      plot_done = 0;
      if (k > 0) begin
        k--;
        if (k == 0) plot_done = 1;
      end
      if (plot_start) begin
        starts++;
        k = dly;
        if (sb.size() == 0) check("sb_unexpected_start", grant, 0);
        else begin
          e = sb.pop_front();
          check("sb_grant", grant, e.g);
          check("sb_op", sched_op, e.op);
        end
      end
      @(negedge clk);
    end
    plot_done = 0;
    check("frame_ends_idle", busy, 0);
  endtask

  initial begin
    int n, st;
    logic [N-1:0] g_or;
    logic ps_or;
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_start", plot_start, 0);
    check("rst_overrun", {overrun, overrun_cnt}, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_op", sched_op, 0);
    reset_n = 1;
    @(negedge clk);

    v[0] = '{act: 4'b0101, mask: 4'b0101, starts: 2};
    v[1] = '{act: 4'b0011, mask: 4'b0011, starts: 4};
    v[2] = '{act: 4'b1111, mask: 4'b1111, starts: 6};
    v[3] = '{act: 4'b1000, mask: 4'b1000, starts: 5};
    v[4] = '{act: 4'b0000, mask: 4'b0000, starts: 1};
    for (int i = 0; i < 5; i++) begin
      push_frame(v[i].act);
      run_frame(v[i].act, 3, st);
      check("tbl_starts", st, v[i].starts);
      check("tbl_drawn_mask", dut.r_drawn_mask, v[i].mask);
      check("tbl_sb_drained", sb.size(), 0);
      sb.delete();
    end
    check("tbl_no_overrun", overrun_cnt, 0);

    // empty frame: exactly 2*N SCAN cycles
    active = '0;
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    n = 0; g_or = '0; ps_or = 0;
    while (busy && n < 50) begin
      n++; g_or |= grant; ps_or |= plot_start;
      @(negedge clk);
    end
    check("empty_busy_cycles", n, 2 * N);
    check("empty_no_grant", {g_or, ps_or}, 0);

    // tick while waiting on client 1
    active = 4'b0010;
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    n = 0;
    while (!plot_start && n < 50) begin n++; @(negedge clk); end
    check("ovr_grant", grant, 4'b0010);
    check("ovr_op", sched_op, OP_DRAW);
    @(negedge clk);
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    check("ovr_pulse", overrun, 1);
    check("ovr_cnt", overrun_cnt, 1);
    @(negedge clk);
    check("ovr_one_cycle", overrun, 0);
    check("ovr_grant_held", grant, 4'b0010);
    plot_done = 1;
    @(negedge clk);
    plot_done = 0;
    n = 0; ps_or = 0;
    while (n < 20) begin
      if (n > 0 || busy) ps_or |= plot_start | (n > 8 && busy);
      n++;
      @(negedge clk);
    end
    check("ovr_no_restart", ps_or, 0);
    check("ovr_idle", busy, 0);
    check("ovr_mask", dut.r_drawn_mask, 4'b0010);

    // plot_done withheld on the erase of client 1; ticks hammer the overrun counter
    active = '0;
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    n = 0;
    while (!plot_start && n < 50) begin n++; @(negedge clk); end
    check("to_grant", grant, 4'b0010);
    check("to_op", sched_op, OP_ERASE);
    check("to_err_before", timeout_err, 0);
    @(negedge clk);
    n = 0;
    while (grant != 0 && n < TO + 100) begin
      frame_tick = (n < 600) ? n[0] : 1'b0;
      n++;
      @(negedge clk);
    end
    frame_tick = 0;
    check("to_wait_cycles", n, TO + 1);
    check("to_err_set", timeout_err, 1);
    check("to_cnt_saturated", overrun_cnt, 8'hFF);
    n = 0; ps_or = 0;
    while (busy && n < 50) begin ps_or |= plot_start; n++; @(negedge clk); end
    check("to_finishes_frame", busy, 0);
    check("to_no_more_jobs", ps_or, 0);
    check("to_mask_unchanged", dut.r_drawn_mask, 4'b0010);

    // reset during WAIT
    active = 4'b0100;
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    n = 0;
    while (!plot_start && n < 50) begin n++; @(negedge clk); end
    check("rw_grant", grant, 4'b0010);
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    check("rw_grant_clear", grant, 0);
    check("rw_busy_clear", busy, 0);
    check("rw_mask_clear", dut.r_drawn_mask, 0);
    check("rw_cnt_clear", overrun_cnt, 0);
    check("rw_err_clear", timeout_err, 0);
    reset_n = 1;
    @(negedge clk);

    model_mask = '0;
    sb.delete();
    push_frame(4'b0001);
    run_frame(4'b0001, 2, st);
    check("post_rst_starts", st, 1);
    check("post_rst_mask", dut.r_drawn_mask, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
